// File: rtl/emif4fpga_pkg.sv
// emif4fpga_pkg: shared constants and types for the EMIF dual-port RAM slice.
// Optional build macro: DPRAM_ID_OVERLAY_EN adds the board-ID hit flag to the read tag.
package emif4fpga_pkg;

    localparam int unsigned DPRAM_AW     = 8;
    localparam int unsigned DPRAM_DW     = 16;
    localparam int unsigned DPRAM_RD_LAT = 2;

    // Requester id width in the read tag; covers NREQ up to 4.
    localparam int unsigned TAG_IDW = 2;

    localparam logic [7:0]  BOARD_ID_ADDR = 8'd4;
    localparam logic [15:0] BOARD_ID_VAL  = 16'hAAAA;

    // Read tag travelling alongside the RAM read latency.
    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
`ifdef DPRAM_ID_OVERLAY_EN
        logic               id_hit;
`endif
    } dpram_tag_t;

endpackage

// File: rtl/dpram_portb_arb_if.sv
// dpram_portb_arb_if: requester-side bus of the port-B arbiter.
// master = requesters, slave = arbiter.
interface dpram_portb_arb_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dpram_portb_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Search starts one past the
// pointer (modulo NREQ); the first asserted request wins.
module rr_arbiter
    import emif4fpga_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [TAG_IDW-1:0] ptr,
    output logic [NREQ-1:0]    gnt,
    output logic [TAG_IDW-1:0] win_idx,
    output logic               win_vld
);

    int unsigned idx;

    // Rotating priority search from ptr+1.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!win_vld && (|(req & (NREQ'(1) << idx)))) begin
                win_vld = 1'b1;
                win_idx = TAG_IDW'(idx);
                gnt     = NREQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/dpram_portb_arb.sv
// dpram_portb_arb: round-robin arbiter/sequencer for port B of the 256x16
// dual-port RAM. One access per cycle; reads return a tagged rvalid pulse
// RD_LAT+1 cycles after acceptance.
// Optional build macro: DPRAM_ID_OVERLAY_EN (reads of BOARD_ID_ADDR return BOARD_ID_VAL).
module dpram_portb_arb
    import emif4fpga_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned AW     = DPRAM_AW,
    parameter int unsigned DW     = DPRAM_DW,
    parameter int unsigned RD_LAT = DPRAM_RD_LAT
) (
    input  logic          outclk_50mhz,
    input  logic          rst,
    dpram_portb_arb_if.slave bus,
    output logic [AW-1:0] address_b,
    output logic [DW-1:0] data_b,
    output logic          rden_b,
    output logic          wren_b,
    input  logic [DW-1:0] q_b
);

    logic [NREQ-1:0]    arb_gnt;
    logic [TAG_IDW-1:0] win_idx;
    logic               win_vld;
    logic [TAG_IDW-1:0] ptr_q;
    logic [TAG_IDW-1:0] issue_id;
    logic               accept;
    logic [AW-1:0]      win_addr;
    logic [DW-1:0]      win_wdata;
    logic               win_we;
    dpram_tag_t         tag_in;
    dpram_tag_t         tag_out;
    dpram_tag_t         tag_sr [RD_LAT];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Grant gating and winner field selection.
    always_comb begin
        bus.gnt   = rst ? '0 : arb_gnt;
        accept    = !rst && win_vld;
        win_addr  = AW'(bus.req_addr >> (32'(win_idx) * AW));
        win_wdata = DW'(bus.req_wdata >> (32'(win_idx) * DW));
        win_we    = |(bus.req_we & arb_gnt);
    end

    // Round-robin pointer: remembers the last winner.
    always_ff @(posedge outclk_50mhz) begin
        if (rst) begin
            ptr_q <= TAG_IDW'(NREQ - 1);
        end else if (accept) begin
            ptr_q <= win_idx;
        end
    end

    // Issue stage: drive RAM port B for one cycle per accepted command.
    always_ff @(posedge outclk_50mhz) begin
        if (rst) begin
            address_b <= '0;
            data_b    <= '0;
            rden_b    <= 1'b0;
            wren_b    <= 1'b0;
            issue_id  <= '0;
        end else begin
            rden_b <= 1'b0;
            wren_b <= 1'b0;
            if (accept) begin
                address_b <= win_addr;
                data_b    <= win_wdata;
                wren_b    <= win_we;
                rden_b    <= !win_we;
                issue_id  <= win_idx;
            end
        end
    end

    // Tag captured from the issued RAM cycle.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = rden_b;
        tag_in.id    = issue_id;
`ifdef DPRAM_ID_OVERLAY_EN
        tag_in.id_hit = (address_b == AW'(BOARD_ID_ADDR));
`endif
        tag_out = tag_sr[RD_LAT-1];
    end

    // Read-tag delay line matching the RAM read latency.
    always_ff @(posedge outclk_50mhz) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            tag_sr[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // Read return: one-cycle rvalid to the owner, data registered from q_b.
    always_ff @(posedge outclk_50mhz) begin
        if (rst) begin
            bus.rvalid <= '0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= '0;
            if (tag_out.valid) begin
                bus.rvalid <= NREQ'(1) << tag_out.id;
`ifdef DPRAM_ID_OVERLAY_EN
                bus.rdata  <= tag_out.id_hit ? DW'(BOARD_ID_VAL) : q_b;
`else
                bus.rdata  <= q_b;
`endif
            end
        end
    end

endmodule
